inst_fetch_queue: RTL and testbench



---
 rtl/inst_fetch_queue.sv | 112 +++++++++++
 tb/tb_inst_fetch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// ---------------------------------------------------------------------------
// inst_fetch_queue
//
// Small FIFO between the I-cache read port and the ID stage. It holds
// fetched {pc, inst} pairs and presents the oldest one to decode
// (show-ahead). When it is empty, decode sees a canonical NOP with pc = 0,
// so the ID stage always gets a legal instruction. A redirect from EX
// flushes the queue in one cycle.
//
// Parameters
//   DEPTH     number of entries (power of two, >= 2)
//   NOP_INST  instruction presented when the queue is empty
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   flush      redirect from EX; empties the queue at the next edge
//   in_valid   fetch side presents a word this cycle
//   in_ready   queue can accept a word (depends on occupancy only)
//   in_pc      PC of the fetched word
//   in_inst    fetched instruction
//   out_valid  head entry is valid
//   out_ready  ID stage consumes the head this cycle
//   out_pc     PC of the head entry (0 when empty)
//   out_inst   head instruction (NOP_INST when empty)
//   count      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Handshake flags come from registered occupancy only, so there is no
  // combinational path from in_valid/out_ready into in_ready/out_valid.
  // When full, a simultaneous pop does not open a slot in the same cycle.
  assign in_ready  = (count_q < FULL_COUNT);
  assign out_valid = (count_q != '0);

  // A flush overrides any transfer attempted in the same cycle.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Storage: written at the write pointer on an accepted push. Flush does
  // not touch the contents because the pointers alone decide validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_pc, in_inst};
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  // Occupancy is tracked separately so full and empty are distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Show-ahead head read; substitute the NOP when nothing is valid so
  // decode never sees stale storage.
  assign head     = mem[rd_ptr];
  assign out_pc   = out_valid ? head[63:32] : 32'h0;
  assign out_inst = out_valid ? head[31:0]  : NOP_INST;
  assign count    = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [63:0] model_q[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .NOP_INST(NOP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .count     (count)
  );

  // Drive one cycle's worth of inputs.
  task automatic applyStimulus(input logic f, input logic iv, input logic [31:0] pc,
                               input logic [31:0] inst, input logic ordy);
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] inst_of(input int i);
    return 32'h0050_0093 + (32'(i) << 20);
  endfunction

  initial begin
    logic        m_push;
    logic        m_pop;
    logic [31:0] rpc;
    logic [63:0] hd;

    // Reset and idle
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_inst", out_inst, NOP);
    checkOutput("rst_out_pc", out_pc, 32'h0);
    #10;
    rst_n = 1'b1;
    tick();

    // Fill with out_ready low; no bypass while empty
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'(i * 4), inst_of(i), 0);
      if (i == 0) checkOutput("no_bypass_valid", 32'(out_valid), 32'd0);
      tick();
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    tick();
    checkOutput("fifth_push_count", 32'(count), 32'd4);
    checkOutput("fifth_push_head", out_pc, 32'h0);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("drain_pc", out_pc, 32'(i * 4));
      checkOutput("drain_inst", out_inst, inst_of(i));
      tick();
    end
    checkOutput("drained_valid", 32'(out_valid), 32'd0);
    checkOutput("drained_nop", out_inst, NOP);
    checkOutput("drained_count", 32'(count), 32'd0);

    // Streaming: one in, one out per cycle, pointers wrap five times
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 1);
      if (k > 0) begin
        checkOutput("stream_count", 32'(count), 32'd1);
        checkOutput("stream_pc", out_pc, 32'h200 + 32'(4 * (k - 1)));
        checkOutput("stream_inst", out_inst, 32'h1000 + 32'(k - 1));
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("stream_last_pc", out_pc, 32'h24C);
    tick();
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Flush with simultaneous push and pop
    applyStimulus(0, 1, 32'h300, 32'h3000, 0);
    tick();
    applyStimulus(0, 1, 32'h304, 32'h3004, 0);
    tick();
    checkOutput("preflush_count", 32'(count), 32'd2);
    applyStimulus(1, 1, 32'h40, 32'h4000, 1);
    tick();
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(0, 1, 32'h100, 32'h0100_0013, 0);
    checkOutput("postflush_nop", out_inst, NOP);
    tick();
    checkOutput("postflush_pc", out_pc, 32'h100);
    checkOutput("postflush_count", 32'(count), 32'd1);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkOutput("postflush_drain", 32'(count), 32'd0);

    // Full plus simultaneous pop: pop taken, push rejected
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h400 + 32'(4 * i), 32'h4400 + 32'(i), 0);
      tick();
    end
    applyStimulus(0, 1, 32'h410, 32'h4404, 1);
    checkOutput("fullpop_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("fullpop_count", 32'(count), 32'd3);
    checkOutput("fullpop_head", out_pc, 32'h404);
    applyStimulus(0, 1, 32'h410, 32'h4404, 0);
    tick();
    checkOutput("refill_count", 32'(count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("fullpop_order", out_pc, 32'h400 + 32'(4 * i));
      tick();
    end

    // Reset asserted mid-stream drops entries without a clock edge
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 32'h500 + 32'(4 * i), 32'h5000, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midrst_pre_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_nop", out_inst, NOP);
    #2;
    rst_n = 1'b1;
    tick();

    // Random stall bursts against a reference queue model
    model_q.delete();
    rpc = 32'h1000;
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 99) < 5), 1'($urandom_range(0, 1)), rpc,
                    $urandom(), 1'($urandom_range(0, 1)));
      checkOutput("rnd_count", 32'(count), 32'(model_q.size()));
      checkOutput("rnd_valid", 32'(out_valid), 32'(model_q.size() != 0));
      checkOutput("rnd_in_ready", 32'(in_ready), 32'(model_q.size() < 4));
      if (model_q.size() != 0) begin
        hd = model_q[0];
        checkOutput("rnd_pc", out_pc, hd[63:32]);
        checkOutput("rnd_inst", out_inst, hd[31:0]);
      end else begin
        checkOutput("rnd_empty_nop", out_inst, NOP);
        checkOutput("rnd_empty_pc", out_pc, 32'h0);
      end
      m_push = in_valid && (model_q.size() < 4) && !flush;
      m_pop  = (model_q.size() != 0) && out_ready && !flush;
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (m_pop) void'(model_q.pop_front());
        if (m_push) model_q.push_back({in_pc, in_inst});
      end
      rpc = rpc + 32'd4;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
